// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, column drive patterns and key map for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_e;
  localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  // Indexed by {row, col}.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer that resets to all-ones (released rows)
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with sweep-level debounce and ghost rejection
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_DONE = CW'(DEBOUNCE_SCANS);
  logic [3:0] row_s, rows_low;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] hits_q, hits_d, hits_new, row_enc;
  logic [2:0] n_low, hits_sum;
  logic [3:0] pos_q, pos_d, pos_new;
  state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [CW-1:0] deb_q, deb_d, deb_inc;
  logic [3:0] key_code_q, key_code_d;
  logic key_valid_q, key_valid_d;
  logic dwell_last, sweep_end, single, same;
  sync_2ff #(.W(4)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (row),
    .q  (row_s)
  );
  always_comb begin
    dwell_last = dwell_q == DWELL_LAST;
    dwell_d = dwell_last ? '0 : dwell_q + DW'(1);
    col_idx_d = dwell_last ? col_idx_q + 2'd1 : col_idx_q;
    rows_low = ~row_s;
    n_low = {2'b0, rows_low[0]} + {2'b0, rows_low[1]} + {2'b0, rows_low[2]} + {2'b0, rows_low[3]};
    // A sweep restarts its hit tally on the col0 sample; the tally saturates at "multiple".
    hits_sum = (col_idx_q == 2'd0 ? 3'd0 : {1'b0, hits_q}) + n_low;
    hits_new = hits_sum > 3'd1 ? 2'd2 : hits_sum[1:0];
    row_enc = rows_low[0] ? 2'd0 : rows_low[1] ? 2'd1 : rows_low[2] ? 2'd2 : 2'd3;
    pos_new = n_low == 3'd1 ? {row_enc, col_idx_q} : pos_q;
    hits_d = dwell_last ? hits_new : hits_q;
    pos_d = dwell_last ? pos_new : pos_q;
    sweep_end = dwell_last && col_idx_q == 2'd3;
    single = hits_new == 2'd1;
    same = single && pos_new == cand_q;
    deb_inc = deb_q == DEB_DONE ? deb_q : deb_q + CW'(1);
    state_d = state_q;
    cand_d = cand_q;
    deb_d = deb_q;
    key_code_d = key_code_q;
    key_valid_d = 1'b0;
    if (sweep_end)
      case (state_q)
        IDLE:
          if (single) begin
            state_d = PRESS_DEB;
            cand_d = pos_new;
            deb_d = CW'(1);
          end
        PRESS_DEB:
          if (same) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_DONE) begin
              state_d = HELD;
              key_code_d = KEY_MAP[cand_q];
              key_valid_d = 1'b1;
            end
          end else if (single) begin
            cand_d = pos_new;
            deb_d = CW'(1);
          end else state_d = IDLE;
        HELD:
          if (!same) begin
            state_d = REL_DEB;
            deb_d = CW'(1);
          end
        REL_DEB:
          if (same) state_d = HELD;
          else begin
            deb_d = deb_inc;
            state_d = deb_inc == DEB_DONE ? IDLE : REL_DEB;
          end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dwell_q <= '0;
      col_idx_q <= '0;
      hits_q <= '0;
      pos_q <= '0;
      state_q <= IDLE;
      cand_q <= '0;
      deb_q <= '0;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      col_idx_q <= col_idx_d;
      hits_q <= hits_d;
      pos_q <= pos_d;
      state_q <= state_d;
      cand_q <= cand_d;
      deb_q <= deb_d;
      key_code_q <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  assign col = COL_DRIVE[col_idx_q];
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held = state_q == HELD || state_q == REL_DEB;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks against a per-sweep keypad model
module tb_keypad_scanner;
  localparam int DEB = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] row, col, key_code;
  logic key_valid, key_held;
  logic [15:0] keys = '0;
  int total = 0;
  int bad = 0;
  int obs_kv, col_bad;
  int m_state, m_cnt, m_cand, exp_kv;
  logic [3:0] m_code;
  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Model states: 0 idle, 1 press debounce, 2 held, 3 release debounce.
  task automatic model_reset;
    m_state = 0; m_cnt = 0; m_cand = 0; m_code = 4'h0; exp_kv = 0;
  endtask

  task automatic model_sweep(input logic [15:0] mask);
    int pos;
    bit single, match;
    single = $countones(mask) == 1;
    pos = -1;
    for (int i = 0; i < 16; i++) if (mask[i]) pos = i;
    match = single && pos == m_cand;
    exp_kv = 0;
    case (m_state)
      0: if (single) begin m_state = 1; m_cand = pos; m_cnt = 1; end
      1: if (match) begin
           m_cnt++;
           if (m_cnt == DEB) begin m_state = 2; m_code = key_map[m_cand]; exp_kv = 1; end
         end else if (single) begin m_cand = pos; m_cnt = 1; end
         else m_state = 0;
      2: if (!match) begin m_state = 3; m_cnt = 1; end
      default: if (match) m_state = 2;
               else begin m_cnt++; if (m_cnt == DEB) m_state = 0; end
    endcase
  endtask

  task automatic run_sweep(input logic [15:0] mask);
    logic [3:0] ce;
    keys = mask;
    obs_kv = 0;
    col_bad = 0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      @(negedge clk);
      ce = 4'b0001 << ((j % 16) / 4);
      if (key_valid) obs_kv++;
      if (col !== ~ce) col_bad++;
    end
    model_sweep(mask);
  endtask

  task automatic test_reset;
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got %b want 1110", col); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got %h want 0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got %b want 0", key_held); end
    rst = 1'b1;
  endtask

  task automatic test_idle_scan;
    for (int s = 0; s < 3; s++) begin
      run_sweep(16'h0000);
      total++; if (col_bad !== 0) begin bad++; $display("FAIL idle_col sweep %0d got %0d bad cycles want 0", s, col_bad); end
      total++; if (obs_kv !== 0) begin bad++; $display("FAIL idle_valid sweep %0d got %0d want 0", s, obs_kv); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL idle_held sweep %0d got %b want 0", s, key_held); end
    end
  endtask

  task automatic test_press_release;
    logic [15:0] seq [8];
    int kv_sum = 0;
    seq = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0000};
    for (int s = 0; s < 8; s++) begin
      run_sweep(seq[s]);
      kv_sum += obs_kv;
      total++; if (obs_kv !== exp_kv) begin bad++; $display("FAIL key5_valid sweep %0d got %0d want %0d", s, obs_kv, exp_kv); end
      total++; if (key_held !== (m_state >= 2)) begin bad++; $display("FAIL key5_held sweep %0d got %b want %0d", s, key_held, m_state >= 2); end
      total++; if (key_code !== m_code) begin bad++; $display("FAIL key5_code sweep %0d got %h want %h", s, key_code, m_code); end
    end
    total++; if (kv_sum !== 1) begin bad++; $display("FAIL key5_pulses got %0d want 1", kv_sum); end
    total++; if (key_code !== 4'h5) begin bad++; $display("FAIL key5_final_code got %h want 5", key_code); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] seq [6];
    int kv_sum = 0;
    run_sweep(16'h0100);
    run_sweep(16'h0100);
    keys = '0;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_outputs got col=%b code=%h valid=%b held=%b want 1110 0 0 0", col, key_code, key_valid, key_held);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    seq = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000};
    for (int s = 0; s < 6; s++) begin
      run_sweep(seq[s]);
      kv_sum += obs_kv;
      total++; if (obs_kv !== exp_kv) begin bad++; $display("FAIL key7_valid sweep %0d got %0d want %0d", s, obs_kv, exp_kv); end
      total++; if (key_held !== (m_state >= 2)) begin bad++; $display("FAIL key7_held sweep %0d got %b want %0d", s, key_held, m_state >= 2); end
      total++; if (key_code !== m_code) begin bad++; $display("FAIL key7_code sweep %0d got %h want %h", s, key_code, m_code); end
    end
    total++; if (kv_sum !== 1) begin bad++; $display("FAIL key7_pulses got %0d want 1", kv_sum); end
  endtask

  task automatic test_bounce;
    int kv_sum = 0;
    for (int s = 0; s < 9; s++) begin
      run_sweep(s % 3 == 2 ? 16'h0000 : 16'h0008);
      kv_sum += obs_kv;
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held sweep %0d got %b want 0", s, key_held); end
    end
    total++; if (kv_sum !== 0) begin bad++; $display("FAIL bounce_pulses got %0d want 0", kv_sum); end
  endtask

  task automatic test_ghost;
    int kv_sum = 0;
    for (int s = 0; s < 6; s++) begin
      run_sweep(16'h0401);
      kv_sum += obs_kv;
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL ghost_held sweep %0d got %b want 0", s, key_held); end
    end
    total++; if (kv_sum !== 0) begin bad++; $display("FAIL ghost_pulses got %0d want 0", kv_sum); end
  endtask

  task automatic test_held_swap;
    logic [15:0] seq [15];
    int kv_sum = 0;
    seq = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h9000, 16'h9000,
            16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000,
            16'h0000, 16'h0000, 16'h0000};
    for (int s = 0; s < 15; s++) begin
      run_sweep(seq[s]);
      kv_sum += obs_kv;
      total++; if (obs_kv !== exp_kv) begin bad++; $display("FAIL swap_valid sweep %0d got %0d want %0d", s, obs_kv, exp_kv); end
      total++; if (key_held !== (m_state >= 2)) begin bad++; $display("FAIL swap_held sweep %0d got %b want %0d", s, key_held, m_state >= 2); end
      total++; if (key_code !== m_code) begin bad++; $display("FAIL swap_code sweep %0d got %h want %h", s, key_code, m_code); end
      if (s == 8) begin
        total++; if (key_code !== 4'hD) begin bad++; $display("FAIL swap_code_d got %h want d", key_code); end
      end
    end
    total++; if (kv_sum !== 2) begin bad++; $display("FAIL swap_pulses got %0d want 2", kv_sum); end
  endtask

  task automatic test_random;
    logic [15:0] mask = '0;
    int a, b, pick;
    for (int s = 0; s < 48; s++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 1) mask = '0;
      else if (pick <= 6 && mask != '0) mask = mask;
      else if (pick <= 8 || pick <= 6) mask = 16'h1 << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        mask = (16'h1 << a) | (16'h1 << b);
      end
      run_sweep(mask);
      total++; if (obs_kv !== exp_kv) begin bad++; $display("FAIL rand_valid sweep %0d mask %h got %0d want %0d", s, mask, obs_kv, exp_kv); end
      total++; if (key_held !== (m_state >= 2)) begin bad++; $display("FAIL rand_held sweep %0d mask %h got %b want %0d", s, mask, key_held, m_state >= 2); end
      total++; if (key_code !== m_code) begin bad++; $display("FAIL rand_code sweep %0d mask %h got %h want %h", s, mask, key_code, m_code); end
      total++; if (col_bad !== 0) begin bad++; $display("FAIL rand_col sweep %0d got %0d bad cycles want 0", s, col_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press_release();
    test_reset_mid();
    test_bounce();
    test_ghost();
    test_held_swap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
